// File: rtl/mac_array_dual.sv
// mac_array_dual: row x col systolic MAC array with weight-stationary (WS) and
// output-stationary (OS) modes plus a counted accumulator drain.
//
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous active-high reset, clears every register
//   in_w    - west activations, slice r feeds row r (WS kernel values during load)
//   in_n    - north input: WS psum lane c, OS weight for column c in the low bw bits
//   inst_w  - [1] execute, [0] kernel load (WS only)
//   mode    - 0 = WS, 1 = OS; latched only while the array is idle
//   drain   - OS pulse starting the accumulator drain
//   clr_w   - WS pulse clearing all weights and load flags
//   out_s   - south psum lanes
//   valid   - per-column out_s qualifier
//   busy    - drain in progress
module mac_array_dual #(
    parameter int unsigned bw      = 4,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned col     = 8,
    parameter int unsigned row     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [row*bw-1:0]      in_w,
    input  logic [col*psum_bw-1:0] in_n,
    input  logic [1:0]             inst_w,
    input  logic                   mode,
    input  logic                   drain,
    input  logic                   clr_w,
    output logic [col*psum_bw-1:0] out_s,
    output logic [col-1:0]         valid,
    output logic                   busy
);

    localparam int unsigned cnt_w = $clog2(row + 1);

    // Per-PE state
    logic [1:0]         inst_q   [row][col];
    logic [bw-1:0]      a_q      [row][col];
    logic [bw-1:0]      b_q      [row][col];
    logic [bw-1:0]      w_q      [row][col];
    logic               loaded_q [row][col];
    logic [psum_bw-1:0] psum_q   [row][col];
    logic               vld_q    [row][col];
    logic [psum_bw-1:0] acc_q    [row][col];

    // Drain / control state
    logic [psum_bw-1:0] out_os_q [col];
    logic               busy_q;
    logic [cnt_w-1:0]   cnt_q;
    logic               mode_q;

    // Per-PE operands seen this cycle
    logic [bw-1:0]      a_in    [row][col];
    logic [bw-1:0]      b_in    [row][col];
    logic [psum_bw-1:0] psum_in [row][col];
    logic [psum_bw-1:0] mac_ws  [row][col];
    logic [psum_bw-1:0] mac_os  [row][col];

    logic       pipe_empty;
    logic       drain_go;
    logic       shift_en;
    logic [1:0] inject;

    // Unsigned activation times signed weight, result modulo 2^psum_bw.
    function automatic logic [psum_bw-1:0] mul_su(input logic [bw-1:0] a,
                                                  input logic [bw-1:0] w);
        logic [psum_bw-1:0] ax;
        logic [psum_bw-1:0] wx;
        ax = {{(psum_bw - bw){1'b0}}, a};
        wx = {{(psum_bw - bw){w[bw-1]}}, w};
        return ax * wx;
    endfunction

    always_comb begin
        pipe_empty = 1'b1;
        for (int r = 0; r < row; r++) begin
            for (int c = 0; c < col; c++) begin
                if (inst_q[r][c] != 2'b00) begin
                    pipe_empty = 1'b0;
                end
            end
        end
    end

    assign drain_go = drain & mode_q & ~busy_q;
    // The accept edge produces the first beat; the remaining row-1 beats follow.
    assign shift_en = drain_go | (busy_q & (cnt_q > cnt_w'(1)));
    // Instructions are squashed at the row-0 inject point while draining.
    assign inject   = busy_q ? 2'b00 : inst_w;

    always_comb begin
        for (int r = 0; r < row; r++) begin
            for (int c = 0; c < col; c++) begin
                if (c == 0) begin
                    a_in[r][c] = in_w[bw*r +: bw];
                end else begin
                    a_in[r][c] = a_q[r][c-1];
                end
                if (r == 0) begin
                    b_in[r][c]    = in_n[psum_bw*c +: bw];
                    psum_in[r][c] = in_n[psum_bw*c +: psum_bw];
                end else begin
                    b_in[r][c]    = b_q[r-1][c];
                    psum_in[r][c] = psum_q[r-1][c];
                end
                mac_ws[r][c] = psum_in[r][c] + mul_su(a_in[r][c], w_q[r][c]);
                mac_os[r][c] = acc_q[r][c] + mul_su(a_in[r][c], b_in[r][c]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= 1'b0;
            busy_q <= 1'b0;
            cnt_q  <= '0;
            for (int c = 0; c < col; c++) begin
                out_os_q[c] <= '0;
            end
            for (int r = 0; r < row; r++) begin
                for (int c = 0; c < col; c++) begin
                    inst_q[r][c]   <= 2'b00;
                    a_q[r][c]      <= '0;
                    b_q[r][c]      <= '0;
                    w_q[r][c]      <= '0;
                    loaded_q[r][c] <= 1'b0;
                    psum_q[r][c]   <= '0;
                    vld_q[r][c]    <= 1'b0;
                    acc_q[r][c]    <= '0;
                end
            end
        end else begin
            if (pipe_empty && !busy_q && !drain_go) begin
                mode_q <= mode;
            end

            // cnt_q counts remaining drain cycles; busy drops as it reaches 0.
            if (drain_go) begin
                busy_q <= 1'b1;
                cnt_q  <= cnt_w'(row);
            end else if (busy_q) begin
                cnt_q <= cnt_q - cnt_w'(1);
                if (cnt_q == cnt_w'(1)) begin
                    busy_q <= 1'b0;
                end
            end

            if (shift_en) begin
                for (int c = 0; c < col; c++) begin
                    out_os_q[c] <= acc_q[row-1][c];
                end
            end

            for (int r = 0; r < row; r++) begin
                for (int c = 0; c < col; c++) begin
                    // Instruction skew: down column 0, then east along each row.
                    if (c != 0) begin
                        inst_q[r][c] <= inst_q[r][c-1];
                    end else if (r != 0) begin
                        inst_q[r][c] <= inst_q[r-1][0];
                    end else begin
                        inst_q[r][c] <= inject;
                    end

                    if (inst_q[r][c] != 2'b00) begin
                        a_q[r][c] <= a_in[r][c];
                        if (mode_q) begin
                            b_q[r][c] <= b_in[r][c];
                        end
                    end

                    if (!mode_q) begin
                        if (clr_w) begin
                            w_q[r][c]      <= '0;
                            loaded_q[r][c] <= 1'b0;
                        end else if (inst_q[r][c][0] && !loaded_q[r][c]) begin
                            w_q[r][c]      <= a_in[r][c];
                            loaded_q[r][c] <= 1'b1;
                        end
                        if (inst_q[r][c][1]) begin
                            psum_q[r][c] <= mac_ws[r][c];
                        end
                        vld_q[r][c] <= inst_q[r][c][1];
                    end else begin
                        vld_q[r][c] <= 1'b0;
                    end

                    // Drain shifts south with zeros entering row 0; it only runs in OS.
                    if (shift_en) begin
                        if (r == 0) begin
                            acc_q[r][c] <= '0;
                        end else begin
                            acc_q[r][c] <= acc_q[r-1][c];
                        end
                    end else if (mode_q && inst_q[r][c][1]) begin
                        acc_q[r][c] <= mac_os[r][c];
                    end
                end
            end
        end
    end

    always_comb begin
        out_s = '0;
        valid = '0;
        for (int c = 0; c < col; c++) begin
            out_s[psum_bw*c +: psum_bw] = mode_q ? out_os_q[c] : psum_q[row-1][c];
            valid[c]                    = mode_q ? busy_q : vld_q[row-1][c];
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_mac_array_dual.sv
// tb_mac_array_dual: directed bench for mac_array_dual (8x8, bw 4, psum_bw 16).
// Inputs change #1 after the rising edge; outputs are sampled in the same window.
module tb_mac_array_dual;

    localparam int bw      = 4;
    localparam int psum_bw = 16;
    localparam int col     = 8;
    localparam int row     = 8;

    typedef logic [col*psum_bw-1:0] vec_t;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [row*bw-1:0]      in_w;
    logic [col*psum_bw-1:0] in_n;
    logic [1:0]             inst_w;
    logic                   mode;
    logic                   drain;
    logic                   clr_w;
    logic [col*psum_bw-1:0] out_s;
    logic [col-1:0]         valid;
    logic                   busy;

    int n_checks = 0;
    int n_pass   = 0;
    logic [psum_bw-1:0] ws_last [col];

    mac_array_dual #(
        .bw      (bw),
        .psum_bw (psum_bw),
        .col     (col),
        .row     (row)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .in_w   (in_w),
        .in_n   (in_n),
        .inst_w (inst_w),
        .mode   (mode),
        .drain  (drain),
        .clr_w  (clr_w),
        .out_s  (out_s),
        .valid  (valid),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input vec_t got, input vec_t exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t rep(input logic [psum_bw-1:0] v);
        vec_t x;
        for (int c = 0; c < col; c++) begin
            x[psum_bw*c +: psum_bw] = v;
        end
        return x;
    endfunction

    // Clear weights, then stream the same kernel value through every row.
    task automatic load_ws(input logic [bw-1:0] w);
        clr_w = 1'b1;
        tick();
        clr_w  = 1'b0;
        in_w   = {row{w}};
        inst_w = 2'b01;
        repeat (col) tick();
        inst_w = 2'b00;
        repeat (row + col + 2) tick();
        check("load_valid", vec_t'(valid), '0);
    endtask

    // One WS execute; lane 0 gets n0 in the cycle after issue, other lanes 0.
    task automatic ws_exec(input string tag, input logic [bw-1:0] act,
                           input logic [psum_bw-1:0] n0, input logic [psum_bw-1:0] exp0,
                           input logic [psum_bw-1:0] expo);
        vec_t           exp_out;
        logic [col-1:0] exp_v;
        in_w   = {row{act}};
        in_n   = '0;
        inst_w = 2'b10;
        for (int k = 1; k <= row + col + 2; k++) begin
            tick();
            if (k == 1) begin
                inst_w            = 2'b00;
                in_n[psum_bw-1:0] = n0;
            end else begin
                in_n = '0;
            end
            for (int c = 0; c < col; c++) begin
                exp_v[c] = (k == row + 1 + c);
                if (k >= row + 1 + c) begin
                    exp_out[psum_bw*c +: psum_bw] = (c == 0) ? exp0 : expo;
                end else begin
                    exp_out[psum_bw*c +: psum_bw] = ws_last[c];
                end
            end
            check({tag, "_valid"}, vec_t'(valid), vec_t'(exp_v));
            check({tag, "_out"}, out_s, exp_out);
        end
        for (int c = 0; c < col; c++) begin
            ws_last[c] = (c == 0) ? exp0 : expo;
        end
    endtask

    // Drain pulse; beat j carries base - j*step. guard injects an inst, a repeated
    // drain and a mode toggle while busy.
    task automatic drain_run(input string tag, input logic [psum_bw-1:0] base,
                             input logic [psum_bw-1:0] step, input int beats, input bit guard);
        logic [psum_bw-1:0] beat_v;
        beat_v = base;
        check({tag, "_idle_busy"}, vec_t'(busy), '0);
        drain = 1'b1;
        for (int k = 1; k <= beats; k++) begin
            tick();
            drain  = 1'b0;
            inst_w = 2'b00;
            if (guard) begin
                if (k == 2) mode = 1'b0;
                if (k == 3) begin
                    inst_w = 2'b10;
                    drain  = 1'b1;
                end
                if (k == row) mode = 1'b1;
                if (k >= 3) check({tag, "_mode_hold"}, vec_t'(dut.mode_q), vec_t'(1'b1));
            end
            check({tag, "_valid"}, vec_t'(valid), vec_t'({col{1'b1}}));
            check({tag, "_busy"}, vec_t'(busy), vec_t'(1'b1));
            check({tag, "_beat"}, out_s, rep(beat_v));
            beat_v = beat_v - step;
        end
        if (beats == row) begin
            tick();
            drain = 1'b0;
            check({tag, "_end_busy"}, vec_t'(busy), '0);
            check({tag, "_end_valid"}, vec_t'(valid), '0);
        end
    endtask

    initial begin
        reset  = 1'b1;
        in_w   = '0;
        in_n   = '0;
        inst_w = 2'b00;
        mode   = 1'b0;
        drain  = 1'b0;
        clr_w  = 1'b0;
        for (int c = 0; c < col; c++) ws_last[c] = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_out", out_s, '0);
        check("rst_valid", vec_t'(valid), '0);
        check("rst_busy", vec_t'(busy), '0);
        check("rst_mode", vec_t'(dut.mode_q), '0);

        // WS: weight 1, activation 3 -> 8*3 per lane
        load_ws(4'h1);
        ws_exec("ws_basic", 4'h3, 16'h0000, 16'h0018, 16'h0018);

        // WS: weight -1, activation 15 -> 0x8000 - 120 wraps to 0x7F88; other lanes -120
        load_ws(4'hF);
        ws_exec("ws_wrap", 4'hF, 16'h8000, 16'h7F88, 16'hFF88);

        // WS re-load: weight 2, activation 1 -> 16, no residue
        load_ws(4'h2);
        ws_exec("ws_reload", 4'h1, 16'h0000, 16'h0010, 16'h0010);

        // Mode change requested while an inst is in flight must wait for an empty pipe
        in_w   = {row{4'h1}};
        in_n   = '0;
        inst_w = 2'b10;
        tick();
        inst_w = 2'b00;
        mode   = 1'b1;
        for (int k = 1; k <= row + col; k++) begin
            check("mode_inflight", vec_t'(dut.mode_q), '0);
            tick();
        end
        check("mode_switched", vec_t'(dut.mode_q), vec_t'(1'b1));
        check("os_idle_out", out_s, '0);
        check("os_idle_valid", vec_t'(valid), '0);

        // OS: 4 executes of 2*3 -> 24 per PE; upper bits of in_n lanes ignored
        in_w   = {row{4'h2}};
        in_n   = {col{16'h5A53}};
        inst_w = 2'b10;
        repeat (4) tick();
        inst_w = 2'b00;
        for (int k = 1; k <= row + col + 2; k++) begin
            tick();
            check("os_compute_valid", vec_t'(valid), '0);
        end
        drain_run("drain1", 16'd24, 16'd0, row, 1'b1);
        drain_run("drain2", 16'd0, 16'd0, row, 1'b0);

        // OS: row r activation r+1, weight 3 -> row r holds 3*(r+1); bottom row first
        for (int r = 0; r < row; r++) in_w[bw*r +: bw] = 4'(r + 1);
        inst_w = 2'b10;
        tick();
        inst_w = 2'b00;
        repeat (row + col + 2) tick();
        drain_run("drain_rst", 16'd24, 16'd3, 3, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_out", out_s, '0);
        check("midrst_valid", vec_t'(valid), '0);
        check("midrst_busy", vec_t'(busy), '0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("postrst_mode", vec_t'(dut.mode_q), '0);
        tick();
        check("postrst_mode_os", vec_t'(dut.mode_q), vec_t'(1'b1));
        drain_run("drain_post", 16'd0, 16'd0, row, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mac_array_dual.md
# mac_array_dual

Second-generation systolic MAC array. It replaces the weight-stationary-only array with a fully parametrised `row` x `col` grid of processing elements (PEs). The grid runs in two modes, weight-stationary (WS) and output-stationary (OS), and includes a counted accumulator drain. It sits between the activation/weight L0 feeders (west and north) and the output FIFO/SFP (south).

## Interface
- `bw`, 4: activation/weight width. Activations are unsigned; weights are two's-complement.
- `psum_bw`, 16: partial-sum/accumulator width, signed.
- `col`, 8: PE columns (output channels).
- `row`, 8: PE rows (input channels).
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-high; clears every register.
- `in_w`  in  row*bw: west activations (WS: also the kernel during load). Slice r (bits `bw*(r+1)-1 : bw*r`) feeds row r.
- `in_n`  in  col*psum_bw: north input. WS: psum lane c. OS: weight for column c in bits `[psum_bw*c+bw-1 : psum_bw*c]`, upper bits ignored.
- `inst_w`  in  2: [1] execute, [0] kernel load (WS only).
- `mode`  in  1: 0 = WS, 1 = OS. Latched into `mode_q` only while idle.
- `drain`  in  1: OS single-cycle pulse that starts the accumulator drain.
- `clr_w`  in  1: WS single-cycle pulse that clears all weights and load flags.
- `out_s`  out  col*psum_bw: south psum lanes.
- `valid`  out  col: per-column `out_s` qualifier.
- `busy`  out  1: a drain is in progress.

## Operation
- **Instruction skew.** `inst_w` is registered once per row: row r sees it r+1 cycles after issue. Within a row it moves one PE east per cycle. Each PE forwards its west operand east in any cycle where its inst is non-zero.
- **WS load (inst[0]).**
  - A PE whose `loaded` flag is 0 captures the west value into `w_q` and sets `loaded`.
  - A loaded PE forwards the value east instead.
  - Result: the first kernel value reaches the easternmost PE.
- **WS execute (inst[1]).**
  - `psum_out <= psum_in + sext(a) * w_q`.
  - The product uses `{1'b0,a}` x signed `w_q` and is sign-extended to `psum_bw`.
  - The sum wraps modulo 2^psum_bw.
  - `valid_q <= 1`; otherwise `valid_q <= 0`.
  - `psum_out` holds its value when not executing.
- **WS clear.** `clr_w` zeroes every `w_q` and `loaded` flag on the next edge. It is ignored in OS.
- **OS execute (inst[1]).**
  - `acc <= acc + sext(a) * b`, with the same sign rules and wrap.
  - `a` moves east and `b` moves south, one register per PE.
  - inst[0] is ignored.
  - `valid` stays 0 during compute.
- **OS drain.**
  - `drain` while not busy sets `busy` and loads the counter with `row`.
  - Each cycle, accumulators shift south one row; the bottom row drives `out_s` with `valid` = all ones, and zeros enter the top row.
  - The counter decrements each cycle; `busy` drops when it reaches 0, after exactly `row` valid beats, bottom row first.
  - All `acc` are 0 afterwards.
  - During drain, `inst_w` and a repeated `drain` are ignored: instructions are squashed to 00 at the row-0 inject point.
  - `drain` in WS is ignored.
- **Mode latch.** `mode_q <= mode` only when the whole inst pipeline is 00 and `busy` = 0. Otherwise `mode_q` holds.
- **`valid` source.** In WS, `valid[c]` is the bottom-row PE(c) `valid_q`. In OS it is the drain flag.

## Timing
- **Reset values:** `out_s` = 0, `valid` = 0, `busy` = 0, `mode_q` = 0 (WS), all `w_q`/`loaded`/`acc`/operand registers = 0.
- **Issue alignment:** if `inst_w` is issued in cycle t, PE(r,c) acts on the edge ending cycle t+1+r+c.
  - The caller must drive `in_w` slice r in cycle t+1+r.
  - In WS, `in_n` lane c is driven in cycle t+1+c.
  - In OS, the weight for column c is driven in cycle t+1+c.
- **WS latency:** `out_s[c]` and `valid[c]` for an inst issued at t appear in cycle t+1+row+c.
- **OS drain latency:** `drain` sampled at t gives `valid` and the first row (r = row-1) in cycle t+1, and the last row (r = 0) in cycle t+row. `busy` is high for cycles t+1 .. t+row.
- **Reset mid-drain or mid-compute:** immediate return to the reset values; no partial beats.
- **Throughput:** one inst per cycle back-to-back in both modes. A new OS compute may be issued in the cycle after `busy` falls.

## Test plan
- **WS load + single execute (8x8).**
  - Stimulus: load weight 1 in every PE, then one execute with activation 3 in every row and `in_n` = 0.
  - Required: `out_s[c]` = 24 and `valid[c]` = 1 in cycle t+9+c only.
- **WS signed wrap.**
  - Stimulus: weight -1 (4'hF), activation 15, `in_n` lane = 16'h8000.
  - Required: column 0 out = 16'h8000 - 120 wraps to 16'h7F88.
- **WS re-load.**
  - Stimulus: `clr_w`, load weight 2, execute activation 1 in all rows.
  - Required: `out_s` = 16 per lane, with no residue from the old weights.
- **OS accumulate + drain (8x8).**
  - Stimulus: 4 executes of activation 2 and weight 3, then a `drain` pulse.
  - Required: 8 consecutive beats, each lane = 24; `valid` = 8'hFF; `busy` high for 8 cycles; a second drain then outputs all zeros.
- **Mode switch guard.**
  - Stimulus: toggle `mode` while an inst is in flight or `busy` = 1.
  - Required: `mode_q` unchanged until the pipeline is empty.
  - Stimulus: inst and `drain` pulses issued during a drain.
  - Required: both are ignored.
- **Async reset mid-drain (cycle 3 of 8).**
  - Required: `valid`, `busy` and `out_s` go to 0 immediately; after release, a drain outputs zeros.
